unidade_controle_multiciclo: RTL and testbench

Control unit for the multicycle processor. It walks each instruction through time steps T0–T3 and drives every datapath control signal: IR load, the one-hot register-file enables, the A/G register enables, the ALU operation and the single bus-source select. The datapath (R0–R7, A, G, ALU, bus mux) instantiates this block and feeds back the latched instruction word and the G-nonzero flag.

---
 rtl/unidade_controle_multiciclo.sv | 171 +++++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle processor control unit: sequences T0..T3 and drives the
// datapath enables, ALU operation and the single bus-source select.
module unidade_controle_multiciclo #(
    parameter int IR_W = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Run,
    input  logic [IR_W-1:0] IR,
    input  logic            Gnz,
    output logic            IRin,
    output logic [7:0]      Rin,
    output logic [7:0]      Rout,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic            DINout,
    output logic [2:0]      ula_op,
    output logic            Done,
    output logic [1:0]      Tstep
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_MVNZ = 3'b111;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_AND = 3'b010;
    localparam logic [2:0] ULA_OR  = 3'b011;
    localparam logic [2:0] ULA_SLT = 3'b100;

    state_t state, state_nxt;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] rx_oh;
    logic [7:0] ry_oh;
    logic       is_alu;
    logic       unused_ir;

    assign opcode    = IR[IR_W-1:IR_W-3];
    assign rx        = IR[IR_W-4:IR_W-6];
    assign ry        = IR[IR_W-7:IR_W-9];
    assign unused_ir = ^IR[IR_W-10:0];

    assign rx_oh = 8'd1 << rx;
    assign ry_oh = 8'd1 << ry;

    always_comb begin
        is_alu = 1'b0;
        unique case (opcode)
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_SLT: is_alu = 1'b1;
            default:       is_alu = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= T0;
        else       state <= state_nxt;
    end

    // Outputs are combinational; Reset masks every one of them in-cycle
    always_comb begin
        state_nxt = state;
        IRin      = 1'b0;
        Rin       = 8'd0;
        Rout      = 8'd0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        Gout      = 1'b0;
        DINout    = 1'b0;
        ula_op    = ULA_ADD;
        Done      = 1'b0;

        unique case (state)
            T0: begin
                if (Run) begin
                    IRin      = 1'b1;
                    state_nxt = T1;
                end else begin
                    state_nxt = T0;
                end
            end
            T1: begin
                if (is_alu) begin
                    Rout      = rx_oh;
                    Ain       = 1'b1;
                    state_nxt = T2;
                end else begin
                    Done      = 1'b1;
                    state_nxt = T0;
                    unique case (opcode)
                        OP_MV: begin
                            Rout = ry_oh;
                            Rin  = rx_oh;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            Rin    = rx_oh;
                        end
                        OP_MVNZ: begin
                            if (Gnz) begin
                                Rout = ry_oh;
                                Rin  = rx_oh;
                            end
                        end
                        default: begin
                            Rout = 8'd0;
                        end
                    endcase
                end
            end
            T2: begin
                if (is_alu) begin
                    Rout      = ry_oh;
                    Gin       = 1'b1;
                    state_nxt = T3;
                    unique case (opcode)
                        OP_ADD:  ula_op = ULA_ADD;
                        OP_SUB:  ula_op = ULA_SUB;
                        OP_AND:  ula_op = ULA_AND;
                        OP_OR:   ula_op = ULA_OR;
                        OP_SLT:  ula_op = ULA_SLT;
                        default: ula_op = ULA_ADD;
                    endcase
                end else begin
                    state_nxt = T0;
                end
            end
            T3: begin
                if (is_alu) begin
                    Gout = 1'b1;
                    Rin  = rx_oh;
                    Done = 1'b1;
                end
                state_nxt = T0;
            end
            default: state_nxt = T0;
        endcase

        if (Reset) begin
            IRin   = 1'b0;
            Rin    = 8'd0;
            Rout   = 8'd0;
            Ain    = 1'b0;
            Gin    = 1'b0;
            Gout   = 1'b0;
            DINout = 1'b0;
            ula_op = ULA_ADD;
            Done   = 1'b0;
        end
    end

    assign Tstep = Reset ? 2'd0 : state;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for the multicycle control unit: directed plan steps, then
// randomized traffic against a micro-op program model.
module tb_unidade_controle_multiciclo;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Run;
    logic [15:0] IR;
    logic        Gnz;
    logic        IRin;
    logic [7:0]  Rin;
    logic [7:0]  Rout;
    logic        Ain;
    logic        Gin;
    logic        Gout;
    logic        DINout;
    logic [2:0]  ula_op;
    logic        Done;
    logic [1:0]  Tstep;

    int tests = 0;
    int fails = 0;
    int mstep = 0;
    logic prev_done = 1'b0;

    unidade_controle_multiciclo #(.IR_W(16)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR), .Gnz(Gnz),
        .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin),
        .Gout(Gout), .DINout(DINout), .ula_op(ula_op), .Done(Done),
        .Tstep(Tstep)
    );

    always #5 Clock = ~Clock;

    function automatic logic [26:0] pack(
        input logic irin, input logic [7:0] rin, input logic [7:0] rout,
        input logic ain, input logic gin, input logic gout, input logic din,
        input logic [2:0] uop, input logic done, input logic [1:0] t);
        return {irin, rin, rout, ain, gin, gout, din, uop, done, t};
    endfunction

    function automatic logic [15:0] mk_ir(input logic [2:0] op,
                                          input logic [2:0] x,
                                          input logic [2:0] y);
        return {op, x, y, 7'b0};
    endfunction

    // Instruction length in cycles (fetch cycle included)
    function automatic int ins_len(input logic [2:0] op);
        return (op >= 3'd2 && op <= 3'd6) ? 4 : 2;
    endfunction

    // Micro-op program: what each step of an instruction puts on the datapath
    function automatic logic [26:0] model_out(input logic rst, input logic run,
                                              input logic gnz, input int st,
                                              input logic [15:0] ir);
        logic [2:0] op, x, y;
        logic [7:0] xs, ys;
        op = ir[15:13];
        x  = ir[12:10];
        y  = ir[9:7];
        xs = 8'd0;
        ys = 8'd0;
        xs[x] = 1'b1;
        ys[y] = 1'b1;
        if (rst) return 27'd0;
        if (st == 0) return pack(run, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        if (ins_len(op) == 2) begin
            if (op == 3'd0) return pack(0, xs, ys, 0, 0, 0, 0, 0, 1, 2'd1);
            if (op == 3'd1) return pack(0, xs, 0, 0, 0, 0, 1, 0, 1, 2'd1);
            if (gnz)        return pack(0, xs, ys, 0, 0, 0, 0, 0, 1, 2'd1);
            return pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1);
        end
        if (st == 1) return pack(0, 0, xs, 1, 0, 0, 0, 0, 0, 2'd1);
        if (st == 2) return pack(0, 0, ys, 0, 1, 0, 0, 3'(op - 3'd2), 0, 2'd2);
        return pack(0, xs, 0, 0, 0, 1, 0, 0, 1, 2'd3);
    endfunction

    function automatic logic [26:0] dut_out();
        return pack(IRin, Rin, Rout, Ain, Gin, Gout, DINout, ula_op, Done, Tstep);
    endfunction

    task automatic chk(input string tag, input logic [26:0] got,
                       input logic [26:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic ok);
        tests++;
        assert (ok === 1'b1) else begin
            fails++;
            $error("FAIL %s got=%b exp=1", tag, ok);
        end
    endtask

    // Drive one cycle's inputs, check outputs, advance the model
    task automatic cyc(input logic rst, input logic run, input logic [15:0] ir,
                       input logic gnz, input string tag,
                       input bit use_fixed, input logic [26:0] fixed);
        logic [26:0] m;
        @(negedge Clock);
        Reset = rst;
        Run   = run;
        IR    = ir;
        Gnz   = gnz;
        #1;
        m = model_out(rst, run, gnz, mstep, ir);
        if (use_fixed) chk({tag, "_fix"}, dut_out(), fixed);
        chk(tag, dut_out(), m);
        chk_bit({tag, "_bus"}, $countones({Rout, Gout, DINout}) <= 1);
        chk_bit({tag, "_rin"}, $onehot0(Rin));
        chk_bit({tag, "_done2"}, !(Done && prev_done));
        prev_done = Done;
        if (rst) mstep = 0;
        else if (mstep == 0) mstep = run ? 1 : 0;
        else mstep = (mstep + 1 >= ins_len(ir[15:13])) ? 0 : mstep + 1;
    endtask

    initial begin
        logic [15:0] ir_r;
        Reset = 1'b1;
        Run   = 1'b1;
        IR    = 16'd0;
        Gnz   = 1'b0;

        cyc(1, 1, 16'd0, 0, "rst0", 1, 27'd0);
        cyc(1, 1, 16'd0, 0, "rst1", 1, 27'd0);
        cyc(0, 0, 16'd0, 0, "idle", 1, 27'd0);

        ir_r = mk_ir(3'b001, 3'd3, 3'd0);
        cyc(0, 1, ir_r, 0, "mvi_t0", 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, ir_r, 0, "mvi_t1", 1, pack(0, 8'h08, 0, 0, 0, 0, 1, 0, 1, 1));
        ir_r = mk_ir(3'b000, 3'd5, 3'd3);
        cyc(0, 1, ir_r, 0, "mv_t0", 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(0, 1, ir_r, 0, "mv_t1", 1, pack(0, 8'h20, 8'h08, 0, 0, 0, 0, 0, 1, 1));

        ir_r = mk_ir(3'b011, 3'd1, 3'd2);
        cyc(0, 1, ir_r, 0, "sub_t0", 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(0, 1, ir_r, 1, "sub_t1", 1, pack(0, 0, 8'h02, 1, 0, 0, 0, 0, 0, 1));
        cyc(0, 1, ir_r, 1, "sub_t2", 1, pack(0, 0, 8'h04, 0, 1, 0, 0, 1, 0, 2));
        cyc(0, 1, ir_r, 0, "sub_t3", 1, pack(0, 8'h02, 0, 0, 0, 1, 0, 0, 1, 3));

        ir_r = mk_ir(3'b111, 3'd4, 3'd0);
        cyc(0, 1, ir_r, 1, "mvnz0_t0", 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, ir_r, 0, "mvnz0_t1", 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        cyc(0, 1, ir_r, 0, "mvnz1_t0", 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, ir_r, 1, "mvnz1_t1", 1, pack(0, 8'h10, 8'h01, 0, 0, 0, 0, 0, 1, 1));

        ir_r = mk_ir(3'b010, 3'd1, 3'd2);
        cyc(0, 1, ir_r, 0, "add_t0", 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, ir_r, 0, "add_t1", 1, pack(0, 0, 8'h02, 1, 0, 0, 0, 0, 0, 1));
        cyc(1, 0, ir_r, 0, "add_rst", 1, 27'd0);
        cyc(0, 0, ir_r, 0, "post_rst", 1, 27'd0);
        ir_r = mk_ir(3'b000, 3'd6, 3'd7);
        cyc(0, 1, ir_r, 0, "mv2_t0", 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, ir_r, 0, "mv2_t1", 1, pack(0, 8'h40, 8'h80, 0, 0, 0, 0, 0, 1, 1));

        ir_r = mk_ir(3'b110, 3'd2, 3'd2);
        cyc(0, 1, ir_r, 0, "slt_t0", 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, ir_r, 0, "slt_t1", 1, pack(0, 0, 8'h04, 1, 0, 0, 0, 0, 0, 1));
        cyc(0, 0, ir_r, 0, "slt_t2", 1, pack(0, 0, 8'h04, 0, 1, 0, 0, 4, 0, 2));
        cyc(0, 0, ir_r, 0, "slt_t3", 1, pack(0, 8'h04, 0, 0, 0, 1, 0, 0, 1, 3));

        for (int i = 0; i < 1000; i++) begin
            if (mstep == 0) ir_r = 16'($urandom);
            cyc(($urandom % 50) == 0, 1'($urandom), ir_r, 1'($urandom),
                "rand", 0, 27'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
